char_tx_modulator: RTL

CHAR_TX_MODULATOR -- requirements
Module: char_tx_modulator

---
 rtl/tx_mod_pkg.sv | 25 ++
 rtl/tx_carrier_gen.sv | 25 ++
 rtl/char_tx_modulator.sv | 106 ++++++++++
 3 files changed

// File: rtl/tx_mod_pkg.sv
// Shared types and constants for the OOK character transmitter.
// Holds the FSM state type, the one-cycle-per-sample carrier table and the frame length.
package tx_mod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // start bit + 8 data bits + stop bit
    localparam int FRAME_BITS    = 10;
    localparam int CARRIER_STEPS = 10;

    localparam logic signed [7:0] SINE_LUT [CARRIER_STEPS] = '{
        8'sd0, 8'sd59, 8'sd95, 8'sd95, 8'sd59,
        8'sd0, -8'sd59, -8'sd95, -8'sd95, -8'sd59
    };

    function automatic logic signed [7:0] sine_at(input logic [3:0] phase);
        return (phase < 4'(CARRIER_STEPS)) ? SINE_LUT[phase] : 8'sd0;
    endfunction

endpackage

// File: rtl/tx_carrier_gen.sv
// Free-running carrier: a phase counter that advances every clock and its sine sample.
// It never stops between bits or frames, so the keyed carrier stays phase-continuous.
module tx_carrier_gen
    import tx_mod_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic signed [7:0] sample
);

    logic [3:0] phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (phase == 4'(CARRIER_STEPS - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + 4'd1;
        end
    end

    assign sample = sine_at(phase);

endmodule

// File: rtl/char_tx_modulator.sv
// Character transmitter: frames a byte as start/8 data/stop symbols and on-off keys
// the carrier with the current symbol to produce a registered signed DAC stream.
module char_tx_modulator
    import tx_mod_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 1_600_000,
    parameter int CARRIER_FREQ = 160_000,
    parameter int BAUD_RATE    = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic signed [7:0] dac_out,
    output logic              bit_out,
    output logic              tx_busy
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CLKS_PER_CYC = SYS_CLK_FREQ / CARRIER_FREQ;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (SYS_CLK_FREQ % BAUD_RATE != 0) begin : g_bad_baud
            $error("SYS_CLK_FREQ must be an integer multiple of BAUD_RATE");
        end
        if (SYS_CLK_FREQ % CARRIER_FREQ != 0) begin : g_bad_carrier_div
            $error("SYS_CLK_FREQ must be an integer multiple of CARRIER_FREQ");
        end
        if (CLKS_PER_CYC != CARRIER_STEPS) begin : g_bad_carrier_len
            $error("carrier period must be exactly 10 system clocks");
        end
    endgenerate

    tx_state_t         state, state_nxt;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        char_reg;
    logic              bit_end;
    logic              handshake;
    logic signed [7:0] sample;

    tx_carrier_gen u_carrier (
        .clk    (clk),
        .rst    (rst),
        .sample (sample)
    );

    assign bit_end    = (baud_cnt == BIT_LAST);
    assign char_ready = (state == IDLE) && en && !rst;
    assign handshake  = char_valid && char_ready;

    always_comb begin
        state_nxt = state;
        bit_out   = 1'b1;
        tx_busy   = 1'b1;
        case (state)
            IDLE: begin
                tx_busy = 1'b0;
                if (handshake) state_nxt = START;
            end
            START: begin
                bit_out = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                bit_out = char_reg[bit_idx];
                if (bit_end && bit_idx == 3'(FRAME_BITS - 3)) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_reg <= '0;
            dac_out  <= '0;
        end else begin
            state <= state_nxt;
            // The baud counter idles at zero so START always gets a full bit period.
            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (handshake) char_reg <= char_in;
            // Output stage: keyed sample lags the phase counter and symbol by one clock.
            dac_out <= (bit_out && (tx_busy || en)) ? sample : 8'sd0;
        end
    end

endmodule
